// File: rtl/ex_div_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ex_div_ctrl_pkg
// Shared definitions for the RV32M divide sequencer.
//   - funct3 encodings of DIV/DIVU/REM/REMU and the MULDIV funct7
//   - divide FSM state encoding
// ---------------------------------------------------------------------------
package ex_div_ctrl_pkg;

    localparam logic [2:0] INST_DIV      = 3'b100;
    localparam logic [2:0] INST_DIVU     = 3'b101;
    localparam logic [2:0] INST_REM      = 3'b110;
    localparam logic [2:0] INST_REMU     = 3'b111;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_iter.sv
// ---------------------------------------------------------------------------
// div_iter
// One combinational step of restoring shift-subtract division.
// Ports:
//   rem_i     [XLEN:0]   partial remainder
//   quot_i    [XLEN-1:0] dividend/quotient shift register
//   divisor_i [XLEN-1:0] (absolute) divisor
//   rem_o     [XLEN:0]   next partial remainder
//   quot_o    [XLEN-1:0] next quotient shift register
// ---------------------------------------------------------------------------
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] quot_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN:0]   rem_o,
    output logic [XLEN-1:0] quot_o
);

    logic [XLEN:0] shifted;
    logic          fits;
    logic          unused_rem_msb;

    // The partial remainder is always below the divisor, so its MSB is zero
    // and shifting it out loses nothing.
    assign unused_rem_msb = rem_i[XLEN];
    assign shifted        = {rem_i[XLEN-1:0], quot_i[XLEN-1]};
    assign fits           = (shifted >= {1'b0, divisor_i});

    always_comb begin
        rem_o  = shifted;
        quot_o = {quot_i[XLEN-2:0], 1'b0};
        if (fits) begin
            rem_o     = shifted - {1'b0, divisor_i};
            quot_o[0] = 1'b1;
        end
    end

endmodule

// File: rtl/ex_div_ctrl.sv
// ---------------------------------------------------------------------------
// ex_div_ctrl
// Multi-cycle RV32M divide sequencer beside the execute stage.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start_i            EX holds a DIV/DIVU/REM/REMU
//   inst_i             EX instruction (funct3 = inst_i[14:12])
//   dividend_i         rs1 value
//   divisor_i          rs2 value
//   reg_w_addr_i       destination register
//   flush_i            abort the in-flight divide
//   hold_o             pipeline stall request
//   busy_o             FSM not idle
//   result_valid_o     one-cycle result strobe
//   result_o           quotient or remainder
//   reg_w_ena_o        write-back enable (same as result_valid_o)
//   reg_w_addr_o       destination register of the presented result
// ---------------------------------------------------------------------------
module ex_div_ctrl
    import ex_div_ctrl_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [4:0]      reg_w_addr_i,
    input  logic            flush_i,
    output logic            hold_o,
    output logic            busy_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            reg_w_ena_o,
    output logic [4:0]      reg_w_addr_o
);

    localparam int              CNT_W    = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic             rem_sel_q;      // funct3[1]: 1 = remainder result
    logic [4:0]       rd_q;
    logic [XLEN-1:0]  divisor_q;
    logic [XLEN-1:0]  quot_q;
    logic [XLEN:0]    rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_quot_q;
    logic             neg_rem_q;
    logic [XLEN-1:0]  result_q;
    logic [4:0]       w_addr_q;

    // ---- operand preparation (IDLE) ----
    logic [2:0]      funct3_in;
    logic            is_signed;
    logic            dividend_neg;
    logic            divisor_neg;
    logic            divisor_zero;
    logic            overflow;
    logic            special;
    logic            accept;
    logic [XLEN-1:0] abs_dividend;
    logic [XLEN-1:0] abs_divisor;
    logic [XLEN-1:0] special_res;
    logic            unused_inst;

    assign funct3_in    = inst_i[14:12];
    assign unused_inst  = ^{inst_i[31:15], inst_i[11:0], funct3_in[2]};
    assign is_signed    = ~funct3_in[0];
    assign dividend_neg = is_signed & dividend_i[XLEN-1];
    assign divisor_neg  = is_signed & divisor_i[XLEN-1];
    assign divisor_zero = (divisor_i == '0);
    assign overflow     = is_signed & (dividend_i == INT_MIN) & (divisor_i == '1);
    assign special      = divisor_zero | overflow;
    assign accept       = start_i & ~flush_i;
    assign abs_dividend = dividend_neg ? -dividend_i : dividend_i;
    assign abs_divisor  = divisor_neg  ? -divisor_i  : divisor_i;

    // Divide-by-zero returns all-ones / the original dividend; signed
    // overflow returns INT_MIN / zero. No sign fix-up applies to either.
    always_comb begin
        if (divisor_zero) special_res = funct3_in[1] ? dividend_i : '1;
        else              special_res = funct3_in[1] ? '0 : INT_MIN;
    end

    // ---- iteration step and final sign fix-up ----
    logic [XLEN:0]   iter_rem;
    logic [XLEN-1:0] iter_quot;
    logic [XLEN-1:0] fixed_quot;
    logic [XLEN-1:0] fixed_rem;
    logic [XLEN-1:0] final_res;

    div_iter #(.XLEN(XLEN)) u_div_iter (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (divisor_q),
        .rem_o     (iter_rem),
        .quot_o    (iter_quot)
    );

    assign fixed_quot = neg_quot_q ? -iter_quot : iter_quot;
    assign fixed_rem  = neg_rem_q  ? -iter_rem[XLEN-1:0] : iter_rem[XLEN-1:0];
    assign final_res  = rem_sel_q ? fixed_rem : fixed_quot;

    // ---- next-state logic ----
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DIV_IDLE: if (accept) state_d = special ? DIV_DONE : DIV_CALC;
            DIV_CALC: if (cnt_q == CNT_LAST) state_d = DIV_DONE;
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
        if (flush_i) state_d = DIV_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state_q <= DIV_IDLE;
        else     state_q <= state_d;
    end

    // ---- datapath registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_sel_q  <= 1'b0;
            rd_q       <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            w_addr_q   <= '0;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (accept) begin
                        rem_sel_q  <= funct3_in[1];
                        rd_q       <= reg_w_addr_i;
                        divisor_q  <= abs_divisor;
                        quot_q     <= abs_dividend;
                        rem_q      <= '0;
                        cnt_q      <= '0;
                        neg_quot_q <= (dividend_neg ^ divisor_neg) & ~divisor_zero;
                        neg_rem_q  <= dividend_neg;
                        // Special cases skip CALC, so the result is captured
                        // now to be presented in DONE next cycle.
                        if (special) begin
                            result_q <= special_res;
                            w_addr_q <= reg_w_addr_i;
                        end
                    end
                end
                DIV_CALC: begin
                    if (!flush_i) begin
                        rem_q  <= iter_rem;
                        quot_q <= iter_quot;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            result_q <= final_res;
                            w_addr_q <= rd_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---- outputs ----
    assign hold_o         = ((state_q == DIV_IDLE) & start_i & ~flush_i)
                          | ((state_q == DIV_CALC) & ~flush_i);
    assign busy_o         = (state_q != DIV_IDLE);
    assign result_valid_o = (state_q == DIV_DONE) & ~flush_i;
    assign reg_w_ena_o    = result_valid_o;
    assign result_o       = result_q;
    assign reg_w_addr_o   = w_addr_q;

endmodule

// File: doc/ex_div_ctrl.md
# ex_div_ctrl

Multi-cycle divide sequencer beside the execute stage. It accepts RV32M DIV/DIVU/REM/REMU from EX and runs a 32-iteration shift-subtract division. While it runs, it holds the pipeline through ctrl. It then presents one-cycle result and write-back signals that EX muxes onto its register-write outputs.

## Interface
Parameters:
- XLEN, 32, operand/result width
- ITER, 32, iterations per divide (equals XLEN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- start_i  in  1  EX holds an M-extension divide (opcode `INST_TYPE_R`, funct7 0000001, funct3[2]=1)
- inst_i  in  32  EX instruction; funct3 = inst_i[14:12] selects DIV/DIVU/REM/REMU
- dividend_i  in  32  rs1 value (op1)
- divisor_i  in  32  rs2 value (op2)
- reg_w_addr_i  in  5  destination register
- flush_i  in  1  abort the in-flight divide
- hold_o  out  1  stall request to ctrl (freezes IF/ID/EX)
- busy_o  out  1  FSM not in IDLE
- result_valid_o  out  1  one-cycle result strobe
- result_o  out  32  quotient or remainder
- reg_w_ena_o  out  1  write-back enable, equal to result_valid_o
- reg_w_addr_o  out  5  latched destination register

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - With start_i=1 and flush_i=0, latch funct3, reg_w_addr_i and both operands.
  - Divisor==0 or signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): go to DONE directly.
  - Otherwise go to CALC.
- Operand prep:
  - Signed ops use absolute values.
  - neg_q = sign(dividend) XOR sign(divisor), only for a non-zero divisor.
  - neg_r = sign(dividend).
- CALC, one iteration per cycle:
  - rem (33-bit) = {rem[31:0], quot[31]}; quot <<= 1.
  - If rem ≥ {1'b0, divisor}: rem -= divisor and set quot[0].
  - 5-bit counter runs 0..31; at 31, go to DONE.
- DONE:
  - result_valid_o=1.
  - result_o = funct3[1] ? remainder : quotient, with the sign fix applied in two's complement.
  - Next state IDLE unconditionally.
  - start_i is ignored in DONE because it is still the same instruction.
- Special results:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = dividend.
  - Overflow: quotient 0x80000000, remainder 0.
- hold_o = (IDLE & start_i & ~flush_i) | (CALC & ~flush_i). It is 0 in DONE, so the divide advances that cycle.
- flush_i: any state goes to IDLE next cycle. hold_o drops combinationally. No result_valid_o. Latched data is discarded.
- result_o and reg_w_addr_o keep their last value until the next DONE.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0, rem/quot 0.
- Reset mid-CALC: IDLE next cycle, no strobe.
- Normal divide, start accepted at cycle T:
  - CALC during T+1..T+32.
  - DONE at T+33.
  - hold_o high T..T+32 (33 cycles).
  - Back in IDLE at T+34, so a back-to-back divide is accepted at T+34.
- Special-case divide: DONE at T+1; hold_o high at T only.
- Simultaneous start_i and flush_i in IDLE: the flush wins; nothing is latched.
- Simultaneous flush_i and DONE: the strobe is suppressed.

## Structure
- Shared define.v holds:
  - `INST_DIV` 3'b100, `INST_DIVU` 3'b101, `INST_REM` 3'b110, `INST_REMU` 3'b111
  - `FUNCT7_MULDIV` 7'b0000001
  - `DIV_IDLE`, `DIV_CALC`, `DIV_DONE` 2-bit state encodings
- One sub-module, `div_iter`: combinational single-step shift-subtract (in: rem, quot, divisor; out: next rem, next quot).
- FSM, counter, sign fix-up and hold logic stay in ex_div_ctrl.

## Test plan
- DIVU 100/7, start at T → hold_o high T..T+32; result_valid_o at T+33 with result_o=14; REMU → 2; reg_w_addr_o=latched rd.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIV 7 / 0xFFFFFFFE → 0xFFFFFFFD.
- DIVU 0x1234 / 0 → 0xFFFFFFFF at T+1, hold_o only at T; REMU → 0x1234; DIV by 0 → 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at T+1; REM → 0.
- flush_i at T+10 → IDLE at T+11, hold_o 0 at T+10, no strobe; new DIVU 9/3 at T+12 → 3 at T+45.
- rst at T+5 mid-CALC → all outputs 0 at T+6; back-to-back DIVU at T and T+34 → two strobes at T+33 and T+67, start_i held high during DONE not re-accepted.
